// File: rtl/slant_rx_framebuf.sv
// Receive frame buffer for the slant video link. Per-channel ping-pong Y/C banks,
// swapped only when every enabled channel has completed a frame, plus the pixel
// divider and the slant-rotated readout path.
module slant_rx_framebuf #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned DW       = 5,
  parameter int unsigned AW       = 17,
  parameter int unsigned DEPTH    = 38400,
  parameter int unsigned DIV      = 5,
  parameter int unsigned REP_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         wr_en,
  input  logic [NCH-1:0]         wr_is_y,
  input  logic [NCH*AW-1:0]      wr_addr,
  input  logic [NCH*DW-1:0]      wr_data,
  input  logic [NCH-1:0]         frame_end,
  input  logic [NCH-1:0]         ch_en,
  input  logic [1:0]             bank_force,
  input  logic                   clr_status,
  input  logic                   rd_frame,
  input  logic                   rd_active,
  output logic                   pix_clk,
  output logic                   pix_ce,
  output logic                   rd_valid,
  output logic [DW-1:0]          rd_y,
  output logic [DW-1:0]          rd_c,
  output logic [$clog2(NCH)-1:0] rd_ch,
  output logic                   rd_bank,
  output logic                   swap,
  output logic [NCH-1:0]         overrun
);

  localparam int unsigned CW  = $clog2(NCH);
  localparam int unsigned IW  = $clog2(DEPTH);
  localparam int unsigned DCW = $clog2(DIV);
  localparam int unsigned RAW = AW + REP_LOG2;

  localparam logic [DW-1:0]       CMid     = {1'b1, {(DW - 1){1'b0}}};
  localparam logic [AW-1:0]       DepthLim = AW'(DEPTH);
  localparam logic [DCW-1:0]      CntMax   = DCW'(DIV - 1);
  localparam logic [DCW-1:0]      CntHalf  = DCW'(DIV / 2);
  localparam logic [REP_LOG2-1:0] LineLast = '1;
  localparam logic [CW-1:0]       ChLast   = CW'(NCH - 1);

  // ---------------------------------------------------------------------------
  // Pixel divider
  // ---------------------------------------------------------------------------
  logic [DCW-1:0] cnt_q;

  // Free-running divider; strobes are registered copies of the count decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pix_ce  <= 1'b0;
      pix_clk <= 1'b0;
    end else begin
      cnt_q   <= (cnt_q == CntMax) ? '0 : cnt_q + DCW'(1);
      pix_ce  <= (cnt_q == '0);
      pix_clk <= (cnt_q < CntHalf);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame completion, bank swap and overrun status
  // ---------------------------------------------------------------------------
  logic           wb_q, wb_d;
  logic           rb_q, rb_d;
  logic [NCH-1:0] done_q, done_d;
  logic [NCH-1:0] ovr_d;
  logic           swap_d;
  logic [NCH-1:0] done_set;
  logic           swap_cond;

  assign done_set  = frame_end & ch_en;
  assign swap_cond = (&(done_q | ~ch_en)) && (|ch_en) && !rd_frame && !bank_force[1];

  // Next bank/done/overrun state; a frame_end on the swap cycle seeds the new frame.
  always_comb begin
    wb_d   = wb_q;
    rb_d   = rb_q;
    done_d = done_q;
    ovr_d  = overrun;
    swap_d = 1'b0;
    if (clr_status) ovr_d = '0;
    if (bank_force[1]) begin
      rb_d   = bank_force[0];
      wb_d   = ~bank_force[0];
      done_d = '0;
    end else if (swap_cond) begin
      wb_d   = ~wb_q;
      rb_d   = ~rb_q;
      done_d = done_set;
      swap_d = 1'b1;
    end else begin
      done_d = done_q | done_set;
      ovr_d  = ovr_d | (done_set & done_q);
    end
  end

  // Bank/status registers; rd_bank mirrors the read bank from the first edge on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q    <= 1'b0;
      rb_q    <= 1'b1;
      done_q  <= '0;
      overrun <= '0;
      swap    <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      done_q  <= done_d;
      overrun <= ovr_d;
      swap    <= swap_d;
      rd_bank <= rb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read address / slant control
  // ---------------------------------------------------------------------------
  logic [RAW-1:0]      raddr_q, raddr_d;
  logic [RAW-1:0]      lstart_q, lstart_d;
  logic [CW-1:0]       slant_q, slant_d;
  logic [REP_LOG2-1:0] lcnt_q, lcnt_d;
  logic                act_q, act_d;
  logic                rd_stb;
  logic                line_end;
  logic [AW-1:0]       rd_idx;
  logic                idx_ok;

  assign rd_stb   = pix_ce & rd_active & rd_frame;
  assign line_end = act_q & ~rd_active;
  assign rd_idx   = raddr_q[RAW-1:REP_LOG2];
  assign idx_ok   = rd_idx < DepthLim;
  assign rd_ch    = slant_q;

  // Line bookkeeping: latch line start on rise, rotate and rewind on fall.
  always_comb begin
    raddr_d  = raddr_q;
    lstart_d = lstart_q;
    slant_d  = slant_q;
    lcnt_d   = lcnt_q;
    act_d    = rd_active;
    if (!rd_frame) begin
      raddr_d  = '0;
      lstart_d = '0;
      slant_d  = '0;
      lcnt_d   = '0;
      act_d    = 1'b0;
    end else begin
      if (rd_active && !act_q) lstart_d = raddr_q;
      if (rd_stb) raddr_d = raddr_q + RAW'(1);
      if (line_end) begin
        slant_d = (slant_q == ChLast) ? '0 : slant_q + CW'(1);
        lcnt_d  = lcnt_q + 1'b1;
        // The last replayed line of a group moves on to fresh samples.
        if (lcnt_q != LineLast) raddr_d = lstart_q;
      end
    end
  end

  // Read control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_q  <= '0;
      lstart_q <= '0;
      slant_q  <= '0;
      lcnt_q   <= '0;
      act_q    <= 1'b0;
    end else begin
      raddr_q  <= raddr_d;
      lstart_q <= lstart_d;
      slant_q  <= slant_d;
      lcnt_q   <= lcnt_d;
      act_q    <= act_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel storage: 2 banks x (Y, C), synchronous write and read
  // ---------------------------------------------------------------------------
  logic [NCH*DW-1:0] y_s1, c_s1;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DW-1:0] mem_y [2][DEPTH];
    logic [DW-1:0] mem_c [2][DEPTH];
    logic [AW-1:0] waddr;
    logic [DW-1:0] y_q, c_q;

    assign waddr = wr_addr[g*AW +: AW];

    // Memory port: out-of-range writes are dropped; reads are masked later.
    always_ff @(posedge clk) begin
      if (wr_en[g] && (waddr < DepthLim)) begin
        if (wr_is_y[g]) mem_y[wb_q][waddr[IW-1:0]] <= wr_data[g*DW +: DW];
        else            mem_c[wb_q][waddr[IW-1:0]] <= wr_data[g*DW +: DW];
      end
      if (rd_stb) begin
        y_q <= mem_y[rb_q][rd_idx[IW-1:0]];
        c_q <= mem_c[rb_q][rd_idx[IW-1:0]];
      end
    end

    assign y_s1[g*DW +: DW] = y_q;
    assign c_s1[g*DW +: DW] = c_q;
  end

  // ---------------------------------------------------------------------------
  // Two-stage read pipeline
  // ---------------------------------------------------------------------------
  logic          s1_valid;
  logic          s1_ok;
  logic [CW-1:0] s1_ch;

  // Stage 1: remember which channel was read and whether its data is usable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ok    <= 1'b0;
      s1_ch    <= '0;
    end else begin
      s1_valid <= rd_stb;
      if (rd_stb) begin
        s1_ok <= ch_en[slant_q] & idx_ok;
        s1_ch <= slant_q;
      end
    end
  end

  // Stage 2: select the channel, substitute black for disabled/out-of-range reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_y     <= '0;
      rd_c     <= CMid;
    end else begin
      rd_valid <= s1_valid & rd_frame;
      if (s1_valid && rd_frame) begin
        rd_y <= s1_ok ? y_s1[s1_ch*DW +: DW] : '0;
        rd_c <= s1_ok ? c_s1[s1_ch*DW +: DW] : CMid;
      end
    end
  end

endmodule

// File: tb/tb_slant_rx_framebuf.sv
// Self-checking bench for slant_rx_framebuf: table-driven swap/overrun vectors,
// scoreboarded pixel readout with a line/slant model, and reset sequences.
module tb_slant_rx_framebuf;

  localparam int NCH   = 4;
  localparam int DW    = 5;
  localparam int AW    = 17;
  localparam int DEPTH = 38400;
  localparam int DIV   = 5;
  localparam int REP   = 3;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    wr_en;
  logic [NCH-1:0]    wr_is_y;
  logic [NCH*AW-1:0] wr_addr;
  logic [NCH*DW-1:0] wr_data;
  logic [NCH-1:0]    frame_end;
  logic [NCH-1:0]    ch_en;
  logic [1:0]        bank_force;
  logic              clr_status;
  logic              rd_frame;
  logic              rd_active;
  logic              pix_clk;
  logic              pix_ce;
  logic              rd_valid;
  logic [DW-1:0]     rd_y;
  logic [DW-1:0]     rd_c;
  logic [1:0]        rd_ch;
  logic              rd_bank;
  logic              swap;
  logic [NCH-1:0]    overrun;

  slant_rx_framebuf #(
    .NCH(NCH), .DW(DW), .AW(AW), .DEPTH(DEPTH), .DIV(DIV), .REP_LOG2(REP)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_is_y(wr_is_y), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_end(frame_end), .ch_en(ch_en), .bank_force(bank_force),
    .clr_status(clr_status), .rd_frame(rd_frame), .rd_active(rd_active),
    .pix_clk(pix_clk), .pix_ce(pix_ce), .rd_valid(rd_valid), .rd_y(rd_y), .rd_c(rd_c),
    .rd_ch(rd_ch), .rd_bank(rd_bank), .swap(swap), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  function automatic logic [4:0] fy(int ch, int bank, int a);
    return 5'((ch * 5 + bank * 11 + a) % 32);
  endfunction

  function automatic logic [4:0] fc(int ch, int bank, int a);
    return 5'((ch * 3 + bank * 7 + a * 2 + 1) % 32);
  endfunction

  // Scoreboard and readout model
  typedef struct {
    logic [4:0] y;
    logic [4:0] c;
  } exp_t;

  exp_t sbq[$];
  exp_t e_m;
  exp_t e_chk;
  int   idx_m;
  int   m_addr, m_lstart, m_lcnt, m_slant;
  bit   m_act;
  int   rbank_exp;
  int   n_pop;
  int   swap_cnt;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      m_addr = 0; m_lstart = 0; m_lcnt = 0; m_slant = 0; m_act = 0;
    end else begin
      if (swap) swap_cnt++;
      if (rd_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_valid_unexpected: got rd_valid=1, expected no pending pixel");
        end else begin
          e_chk = sbq.pop_front();
          n_pop++;
          chk("rd_y", rd_y, e_chk.y);
          chk("rd_c", rd_c, e_chk.c);
        end
      end
      if (!rd_frame) begin
        m_addr = 0; m_lstart = 0; m_lcnt = 0; m_slant = 0; m_act = 0;
      end else begin
        if (rd_active && !m_act) m_lstart = m_addr;
        if (pix_ce && rd_active) begin
          idx_m = m_addr >> REP;
          if (!ch_en[m_slant] || idx_m >= DEPTH) e_m = '{5'd0, 5'd16};
          else e_m = '{fy(m_slant, rbank_exp, idx_m), fc(m_slant, rbank_exp, idx_m)};
          sbq.push_back(e_m);
          m_addr++;
        end
        if (!rd_active && m_act) begin
          m_slant = (m_slant + 1) % NCH;
          if (m_lcnt != 7) m_addr = m_lstart;
          m_lcnt = (m_lcnt + 1) % 8;
        end
        m_act = rd_active;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix_clk"}, pix_clk, 0);
    chk({tag, "_pix_ce"}, pix_ce, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_y"}, rd_y, 0);
    chk({tag, "_rd_c"}, rd_c, 16);
    chk({tag, "_rd_ch"}, rd_ch, 0);
    chk({tag, "_rd_bank"}, rd_bank, 0);
    chk({tag, "_swap"}, swap, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  // Called right after reset release between edges.
  task automatic div_after_release();
    chk("ce_before_edge", pix_ce, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("pix_ce_seq", pix_ce, 32'(k % DIV == 0));
      chk("pix_clk_seq", pix_clk, 32'(k % DIV < DIV / 2));
      if (k == 0) chk("rd_bank_after_rst", rd_bank, 1);
    end
  endtask

  // Fill the current write bank for all channels; then try aliasing junk writes.
  task automatic write_bank(input int bank);
    for (int a = 0; a < 20; a++) begin
      for (int p = 0; p < 2; p++) begin
        wr_en   = '1;
        wr_is_y = (p == 1) ? '1 : '0;
        for (int ch = 0; ch < NCH; ch++) begin
          if (a < 16) begin
            wr_addr[ch*AW +: AW] = 17'(a);
            wr_data[ch*DW +: DW] = (p == 1) ? fy(ch, bank, a) : fc(ch, bank, a);
          end else begin
            wr_addr[ch*AW +: AW] = 17'(65536 + a - 16);
            wr_data[ch*DW +: DW] = (p == 1) ? ~fy(ch, bank, a - 16) : ~fc(ch, bank, a - 16);
          end
        end
        cyc(1);
      end
    end
    wr_en = '0;
  endtask

  typedef struct {
    logic [3:0] en;
    logic [3:0] fe;
    logic       clr;
    logic [1:0] bf;
    logic       frame;
    logic [3:0] ovr;
    logic       bank;
    int         swaps;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int w;
    int n_base;

    //          en    fe    clr   bf     frame ovr   bank  swaps
    tbl[0]  = '{4'hF, 4'h7, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 0};
    tbl[1]  = '{4'hF, 4'h8, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1};
    tbl[2]  = '{4'hF, 4'h4, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 0};
    tbl[3]  = '{4'hF, 4'h4, 1'b0, 2'b00, 1'b0, 4'h4, 1'b0, 0};
    tbl[4]  = '{4'hF, 4'h0, 1'b1, 2'b00, 1'b0, 4'h0, 1'b0, 0};
    tbl[5]  = '{4'hF, 4'h4, 1'b1, 2'b00, 1'b0, 4'h4, 1'b0, 0};
    tbl[6]  = '{4'hF, 4'h0, 1'b1, 2'b00, 1'b0, 4'h0, 1'b0, 0};
    tbl[7]  = '{4'hF, 4'h0, 1'b0, 2'b11, 1'b0, 4'h0, 1'b1, 0};
    tbl[8]  = '{4'hF, 4'hF, 1'b0, 2'b11, 1'b0, 4'h0, 1'b1, 0};
    tbl[9]  = '{4'hF, 4'hF, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1};
    tbl[10] = '{4'hF, 4'h0, 1'b0, 2'b10, 1'b0, 4'h0, 1'b0, 0};
    tbl[11] = '{4'hF, 4'h1, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 0};
    tbl[12] = '{4'hF, 4'hE, 1'b0, 2'b00, 1'b1, 4'h0, 1'b0, 0};
    tbl[13] = '{4'hF, 4'h0, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1};
    tbl[14] = '{4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 0};
    tbl[15] = '{4'h1, 4'hE, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 0};
    tbl[16] = '{4'h1, 4'h1, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1};

    rst = 1'b1; wr_en = '0; wr_is_y = '0; wr_addr = '0; wr_data = '0; frame_end = '0;
    ch_en = '1; bank_force = 2'b00; clr_status = 1'b0; rd_frame = 1'b0; rd_active = 1'b0;
    rbank_exp = 0; n_pop = 0; swap_cnt = 0;

    // Reset values and divider start-up
    cyc(3);
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    div_after_release();

    // Bank 0 gets the first frame
    write_bank(0);

    // Swap / overrun / force vectors
    for (int i = 0; i < 17; i++) begin
      ch_en      = tbl[i].en;
      frame_end  = tbl[i].fe;
      clr_status = tbl[i].clr;
      bank_force = tbl[i].bf;
      rd_frame   = tbl[i].frame;
      swap_cnt   = 0;
      cyc(1);
      frame_end  = '0;
      clr_status = 1'b0;
      cyc(4);
      chk($sformatf("vec%0d_overrun", i), overrun, tbl[i].ovr);
      chk($sformatf("vec%0d_rd_bank", i), rd_bank, tbl[i].bank);
      chk($sformatf("vec%0d_swaps", i), swap_cnt, tbl[i].swaps);
    end
    ch_en = '1;

    // Now reading bank 0, writing bank 1
    write_bank(1);

    // Nine lines: slant rotation, replay/rewind, disabled channel on line 1
    rbank_exp = 0;
    n_pop     = 0;
    rd_frame  = 1'b1;
    cyc(3);
    for (int l = 0; l < 9; l++) begin
      ch_en     = (l == 1) ? 4'b1101 : 4'hF;
      rd_active = 1'b1;
      cyc(2);
      chk($sformatf("line%0d_rd_ch", l), rd_ch, l % NCH);
      cyc(78);
      rd_active = 1'b0;
      cyc(10);
    end
    ch_en = '1;
    chk("main_sb_drained", sbq.size(), 0);
    chk("main_pixels", n_pop, 144);
    rd_frame = 1'b0;
    cyc(2);
    chk("blank_rd_ch", rd_ch, 0);
    chk("blank_rd_valid", rd_valid, 0);

    // Overrun during a frame, then asynchronous reset mid-line
    rd_frame  = 1'b1;
    frame_end = 4'b0001; cyc(1);
    frame_end = '0;      cyc(1);
    frame_end = 4'b0001; cyc(1);
    frame_end = '0;      cyc(1);
    chk("ovr_pre_rst", overrun, 1);
    rd_active = 1'b1;
    w = 0;
    while (!rd_valid && w < 50) begin
      cyc(1);
      w++;
    end
    chk("valid_before_rst", rd_valid, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    rd_active = 1'b0;
    rd_frame  = 1'b0;
    rbank_exp = 1;
    cyc(2);
    @(negedge clk);
    rst = 1'b0;
    div_after_release();

    // Memory survives reset: read one line from bank 1
    n_base    = n_pop;
    rd_frame  = 1'b1;
    rd_active = 1'b1;
    cyc(40);
    rd_active = 1'b0;
    cyc(10);
    chk("post_rst_sb_drained", sbq.size(), 0);
    chk("post_rst_pixels", n_pop - n_base, 8);
    rd_frame = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
